// File: rtl/mult_share_arbiter_if.sv
// Bundle of the requester, multiplier and response signals around the
// shared multiplier arbiter.
//
// Handshake semantics: a transfer happens in a cycle where both valid and
// ready are high at the rising clock edge. Once valid is raised, the payload
// stays stable until the transfer. Ready may depend on valid. Valid never
// depends on ready. The multiplier side has no ready: mul_valid and
// mul_rlst_vld are single-cycle strobes.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 20
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          mul_valid;
  logic [DATA_WIDTH-1:0]         mul_a;
  logic [DATA_WIDTH-1:0]         mul_b;
  logic [PSUM_WIDTH-1:0]         mul_rlst;
  logic                          mul_rlst_vld;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [PSUM_WIDTH-1:0]         rsp_data;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          err_orphan;

  // Arbiter view
  modport master (
    input  req_valid, req_a, req_b, mul_rlst, mul_rlst_vld, rsp_ready,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data, rsp_id,
           err_orphan
  );

  // Environment view: requesters, multiplier and consumer
  modport slave (
    output req_valid, req_a, req_b, mul_rlst, mul_rlst_vld, rsp_ready,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data, rsp_id,
           err_orphan
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters. A round-robin
// arbiter issues one operand pair per cycle, an ID queue follows each
// operation through the multiplier, and a credit-protected result FIFO
// presents {id, product} to the consumer.
module mult_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PSUM_WIDTH  = 20,
  parameter int MUL_LATENCY = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input logic                 s_clk,
  input logic                 s_rst,
  mult_share_arbiter_if.master bus
);
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam int IQ_DEPTH  = MUL_LATENCY + 1;
  localparam int IQ_PTR_W  = $clog2(IQ_DEPTH);
  localparam int IQ_CNT_W  = $clog2(IQ_DEPTH + 1);
  localparam int FF_PTR_W  = $clog2(FIFO_DEPTH);

  logic [CNT_WIDTH-1:0] outstanding;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  grant_idx;
  logic [NUM_REQ-1:0]   grant_vec;
  logic                 grant_any;
  logic                 can_grant;
  logic                 pop;

  // ID queue: one entry per operation inside the multiplier
  logic [ID_WIDTH-1:0]  iq_mem [IQ_DEPTH];
  logic [IQ_PTR_W-1:0]  iq_wr;
  logic [IQ_PTR_W-1:0]  iq_rd;
  logic [IQ_CNT_W-1:0]  iq_cnt;
  logic                 iq_pop;
  logic                 orphan;

  // Result FIFO with one extra pointer bit to tell full from empty
  logic [ID_WIDTH+PSUM_WIDTH-1:0] ff_mem [FIFO_DEPTH];
  logic [FF_PTR_W:0]              ff_wr;
  logic [FF_PTR_W:0]              ff_rd;
  logic                           ff_empty;
  logic [ID_WIDTH-1:0]            head_id;
  logic [PSUM_WIDTH-1:0]          head_data;

  function automatic logic [IQ_PTR_W-1:0] iq_next(input logic [IQ_PTR_W-1:0] p);
    iq_next = (p == IQ_PTR_W'(IQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A grant consumes one credit, so neither queue can ever overflow
  assign can_grant = (outstanding < CNT_WIDTH'(FIFO_DEPTH));

  // Round-robin search starting just after the last granted requester
  always_comb begin
    int idx;
    idx       = 0;
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (can_grant && !grant_any && bus.req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_idx      = idx[ID_WIDTH-1:0];
        grant_vec[idx] = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant_vec;
  assign ff_empty      = (ff_wr == ff_rd);
  assign pop           = !ff_empty && bus.rsp_ready;
  assign iq_pop        = bus.mul_rlst_vld && (iq_cnt != '0);
  assign orphan        = bus.mul_rlst_vld && (iq_cnt == '0);

  // Credit counter and round-robin pointer
  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      outstanding <= '0;
      rr_ptr      <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      case ({grant_any, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (grant_any) rr_ptr <= grant_idx;
    end
  end

  // Registered operand issue towards the multiplier; operands hold when idle
  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      bus.mul_valid <= 1'b0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
    end else begin
      bus.mul_valid <= grant_any;
      if (grant_any) begin
        bus.mul_a <= bus.req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        bus.mul_b <= bus.req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ID queue pointers, occupancy and the sticky orphan flag
  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      iq_wr          <= '0;
      iq_rd          <= '0;
      iq_cnt         <= '0;
      bus.err_orphan <= 1'b0;
    end else begin
      if (grant_any) iq_wr <= iq_next(iq_wr);
      if (iq_pop)    iq_rd <= iq_next(iq_rd);
      case ({grant_any, iq_pop})
        2'b10:   iq_cnt <= iq_cnt + 1'b1;
        2'b01:   iq_cnt <= iq_cnt - 1'b1;
        default: iq_cnt <= iq_cnt;
      endcase
      if (orphan) bus.err_orphan <= 1'b1;
    end
  end

  // ID queue storage
  always_ff @(posedge s_clk) begin
    if (grant_any) iq_mem[iq_wr] <= grant_idx;
  end

  // Result FIFO pointers
  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      ff_wr <= '0;
      ff_rd <= '0;
    end else begin
      if (iq_pop) ff_wr <= ff_wr + 1'b1;
      if (pop)    ff_rd <= ff_rd + 1'b1;
    end
  end

  // Result FIFO storage, tagged with the requester that issued the operands
  always_ff @(posedge s_clk) begin
    if (iq_pop) ff_mem[ff_wr[FF_PTR_W-1:0]] <= {iq_mem[iq_rd], bus.mul_rlst};
  end

  // Show-ahead head; forced to zero while empty so outputs read 0 after reset
  assign {head_id, head_data} = ff_mem[ff_rd[FF_PTR_W-1:0]];
  assign bus.rsp_valid        = !ff_empty;
  assign bus.rsp_data         = ff_empty ? '0 : head_data;
  assign bus.rsp_id           = ff_empty ? '0 : head_id;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a 5-cycle multiplier model.
module tb_mult_share_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int PW = 20;
  localparam int IW = 2;

  // Clock and reset
  logic s_clk = 1'b0;
  logic s_rst = 1'b0;
  always #5 s_clk = ~s_clk;

  mult_share_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PSUM_WIDTH(PW)) bus ();

  mult_share_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .MUL_LATENCY(5), .FIFO_DEPTH(8)
  ) dut (
    .s_clk(s_clk),
    .s_rst(s_rst),
    .bus(bus.master)
  );

  logic [DW-1:0] a_op [NR];
  logic [DW-1:0] b_op [NR];
  assign bus.req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign bus.req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};

  // Multiplier model: 5-cycle pipeline, not affected by the arbiter reset
  logic [4:0]           pv = '0;
  logic [PW-1:0]        pd [5];
  logic signed [PW-1:0] prod_w;
  assign prod_w = $signed(bus.mul_a) * $signed(bus.mul_b);
  always @(posedge s_clk) begin
    pv    <= {pv[3:0], bus.mul_valid};
    pd[0] <= prod_w;
    for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
  end
  assign bus.mul_rlst_vld = pv[4];
  assign bus.mul_rlst     = pd[4];

  // Scoreboard
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [IW+PW-1:0] exp_q[$];

  // Products of base operands a=i+1, b=-(i+2), worked out by hand
  logic [PW-1:0] base_prod [NR] = '{20'hFFFFE, 20'hFFFFA, 20'hFFFF4, 20'hFFFEC};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Every accepted response is compared with the head of the expected queue
  always @(negedge s_clk) begin
    if (s_rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) check("rsp_unexpected", exp_q.size(), 1);
      else check("rsp", {bus.rsp_id, bus.rsp_data}, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge s_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_exp(input logic [IW-1:0] id, input logic [PW-1:0] p);
    exp_q.push_back({id, p});
  endtask

  task automatic set_base_ops();
    a_op[0] = 8'h01; b_op[0] = 8'hFE;
    a_op[1] = 8'h02; b_op[1] = 8'hFD;
    a_op[2] = 8'h03; b_op[2] = 8'hFC;
    a_op[3] = 8'h04; b_op[3] = 8'hFB;
  endtask

  task automatic do_reset();
    step();
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_mul_valid"}, bus.mul_valid, 0);
    check({tag, "_mul_a"}, bus.mul_a, 0);
    check({tag, "_mul_b"}, bus.mul_b, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_err_orphan"}, bus.err_orphan, 0);
  endtask

  logic [DW-1:0] va [4] = '{8'h80, 8'h7F, 8'h80, 8'h05};
  logic [DW-1:0] vb [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFE};
  logic [PW-1:0] vp [4] = '{20'h04000, 20'h03F01, 20'hFC080, 20'hFFFF6};

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end

    // Reset values
    step();
    step();
    check_reset_outputs("reset");
    s_rst = 1'b1;

    // Single request: 0xFD * 0x07 = -21
    step();
    a_op[0] = 8'hFD;
    b_op[0] = 8'h07;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    settle();
    check("single_grant", bus.req_ready, 4'b0001);
    push_exp(2'd0, 20'hFFFEB);
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) bus.req_valid = '0;
      settle();
      check("single_rsp_valid", bus.rsp_valid, (k == 7) ? 1 : 0);
      if (k == 1) begin
        check("single_mul_valid", bus.mul_valid, 1);
        check("single_mul_a", bus.mul_a, 8'hFD);
        check("single_mul_b", bus.mul_b, 8'h07);
      end
      if (k == 2) begin
        check("single_mul_idle", bus.mul_valid, 0);
        check("single_mul_a_hold", bus.mul_a, 8'hFD);
      end
      if (k == 7) begin
        check("single_rsp_data", bus.rsp_data, 20'hFFFEB);
        check("single_rsp_id", bus.rsp_id, 0);
      end
    end
    drain(20);

    // All requesters valid, consumer always ready
    do_reset();
    set_base_ops();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      settle();
      check("rr_all", bus.req_ready, 1 << (k % 4));
      push_exp(IW'(k % 4), base_prod[k % 4]);
      step();
    end
    bus.req_valid = '0;
    drain(30);

    // Consumer stalled: exactly 8 credits, then blocked
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("fill_grant", bus.req_ready, 1 << (k % 4));
      push_exp(IW'(k % 4), base_prod[k % 4]);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      settle();
      check("full_block", bus.req_ready, 0);
      step();
    end
    settle();
    check("full_rsp_valid", bus.rsp_valid, 1);
    check("full_rsp_data", bus.rsp_data, base_prod[0]);
    check("full_rsp_id", bus.rsp_id, 0);
    bus.rsp_ready = 1'b1;
    settle();
    check("pop_cycle_no_grant", bus.req_ready, 0);
    step();
    bus.req_valid = 4'b0001;
    settle();
    check("resume_grant", bus.req_ready, 4'b0001);
    push_exp(2'd0, base_prod[0]);
    step();
    bus.req_valid = '0;
    drain(40);

    // Grant and pop in the same cycle at 7 outstanding
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      settle();
      check("pre7_grant", bus.req_ready, 1 << ((k + 1) % 4));
      push_exp(IW'((k + 1) % 4), base_prod[(k + 1) % 4]);
      step();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 8; k++) step();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    settle();
    check("grant_and_pop", bus.req_ready, 4'b0001);
    push_exp(2'd0, base_prod[0]);
    step();
    bus.rsp_ready = 1'b0;
    settle();
    check("after_grant_pop", bus.req_ready, 4'b0010);
    push_exp(2'd1, base_prod[1]);
    step();
    settle();
    check("full_again", bus.req_ready, 0);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    drain(40);

    // Reset with three operations in flight
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("pre_rst_grant", bus.req_ready, 1 << ((k + 2) % 4));
      step();
    end
    bus.req_valid = '0;
    step();
    s_rst = 1'b0;
    step();
    s_rst = 1'b1;
    settle();
    check_reset_outputs("midrst");
    for (int k = 6; k < 12; k++) begin
      step();
      settle();
      check("orphan_rsp_valid", bus.rsp_valid, 0);
      if (k >= 7) check("orphan_flag", bus.err_orphan, 1);
    end

    // Requester 2 alone, one request every third cycle
    bus.rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      a_op[2] = va[g];
      b_op[2] = vb[g];
      bus.req_valid = 4'b0100;
      settle();
      check("sparse_grant", bus.req_ready, 4'b0100);
      push_exp(2'd2, vp[g]);
      step();
      bus.req_valid = '0;
      settle();
      check("sparse_mul_valid", bus.mul_valid, 1);
      check("sparse_mul_a", bus.mul_a, va[g]);
      check("sparse_mul_b", bus.mul_b, vb[g]);
      step();
      settle();
      check("sparse_mul_idle", bus.mul_valid, 0);
      step();
    end
    bus.req_valid = 4'b1010;
    settle();
    check("rr_after_2", bus.req_ready, 4'b1000);
    push_exp(2'd3, base_prod[3]);
    step();
    settle();
    check("rr_after_3", bus.req_ready, 4'b0010);
    push_exp(2'd1, base_prod[1]);
    step();
    bus.req_valid = '0;
    drain(30);
    check("orphan_sticky", bus.err_orphan, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
